// File: rtl/ex_stage_if.sv
// Execute-stage bundle: ID/EX register contents in, EX/MEM register contents out.
// master drives the ID/EX side, slave is the execute stage itself.
interface ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int ALUC_W = 4,
    parameter int REG_W  = 5
);
    logic              id_valid_i;
    logic              exe_write_reg;
    logic              exe_mem_to_reg;
    logic              exe_write_mem;
    logic [ALUC_W-1:0] exe_aluc;
    logic              exe_shift;
    logic              exe_alu_imm;
    logic [DATA_W-1:0] operand_1_i;
    logic [DATA_W-1:0] operand_2_i;
    logic [DATA_W-1:0] operand_imm_i;
    logic [REG_W-1:0]  des_r_i;
    logic              mem_stall_i;
    logic              flush_i;
    logic              ex_ready_o;
    logic              mem_valid_o;
    logic              mem_write_reg_o;
    logic              mem_mem_to_reg_o;
    logic              mem_write_mem_o;
    logic [DATA_W-1:0] alu_result_o;
    logic [DATA_W-1:0] store_data_o;
    logic [REG_W-1:0]  mem_des_r_o;

    modport master (
        output id_valid_i, exe_write_reg, exe_mem_to_reg, exe_write_mem,
        output exe_aluc, exe_shift, exe_alu_imm,
        output operand_1_i, operand_2_i, operand_imm_i, des_r_i,
        output mem_stall_i, flush_i,
        input  ex_ready_o, mem_valid_o, mem_write_reg_o, mem_mem_to_reg_o,
        input  mem_write_mem_o, alu_result_o, store_data_o, mem_des_r_o
    );

    modport slave (
        input  id_valid_i, exe_write_reg, exe_mem_to_reg, exe_write_mem,
        input  exe_aluc, exe_shift, exe_alu_imm,
        input  operand_1_i, operand_2_i, operand_imm_i, des_r_i,
        input  mem_stall_i, flush_i,
        output ex_ready_o, mem_valid_o, mem_write_reg_o, mem_mem_to_reg_o,
        output mem_write_mem_o, alu_result_o, store_data_o, mem_des_r_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus EX/MEM output registers.
// Define EX_MUL_EN to add the 32-cycle iterative shift-add multiplier (opcode 10).
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int ALUC_W = 4,
    parameter int REG_W  = 5
) (
    input logic       clk,
    input logic       rst_n,
    ex_stage_if.slave bus
);
    localparam logic [ALUC_W-1:0] OP_ADD = ALUC_W'(0);
    localparam logic [ALUC_W-1:0] OP_SUB = ALUC_W'(1);
    localparam logic [ALUC_W-1:0] OP_AND = ALUC_W'(2);
    localparam logic [ALUC_W-1:0] OP_OR  = ALUC_W'(3);
    localparam logic [ALUC_W-1:0] OP_XOR = ALUC_W'(4);
    localparam logic [ALUC_W-1:0] OP_LUI = ALUC_W'(5);
    localparam logic [ALUC_W-1:0] OP_SLL = ALUC_W'(6);
    localparam logic [ALUC_W-1:0] OP_SRL = ALUC_W'(7);
    localparam logic [ALUC_W-1:0] OP_SRA = ALUC_W'(8);
    localparam logic [ALUC_W-1:0] OP_SLT = ALUC_W'(9);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] alu_res;
    logic              ex_ready;
    logic              accept;
    logic              alu_take;
    logic              wr_eff;

    logic              r_valid;
    logic              r_wr;
    logic              r_m2r;
    logic              r_wm;
    logic [DATA_W-1:0] r_res;
    logic [DATA_W-1:0] r_sd;
    logic [REG_W-1:0]  r_des;

    assign op_a   = bus.operand_1_i;
    assign op_b   = bus.exe_alu_imm ? bus.operand_imm_i : bus.operand_2_i;
    assign shamt  = bus.exe_shift ? bus.operand_imm_i[10:6] : bus.operand_1_i[4:0];
    assign accept = bus.id_valid_i & ex_ready;
    assign wr_eff = bus.exe_write_reg & (bus.des_r_i != '0);

    always_comb begin
        alu_res = '0;
        case (bus.exe_aluc)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_LUI:  alu_res = op_b << 16;
            OP_SLL:  alu_res = bus.operand_2_i << shamt;
            OP_SRL:  alu_res = bus.operand_2_i >> shamt;
            OP_SRA:  alu_res = DATA_W'($signed(bus.operand_2_i) >>> shamt);
            OP_SLT:  alu_res = DATA_W'($signed(op_a) < $signed(op_b));
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MUL_EN
    localparam logic [ALUC_W-1:0] OP_MUL = ALUC_W'(10);

    typedef enum logic {IDLE, MUL_BUSY} state_e;

    state_e            state;
    logic [5:0]        cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplr;
    logic [DATA_W-1:0] acc_nxt;
    logic [DATA_W-1:0] product;
    logic              mul_done;
    logic              mul_take;
    logic              lat_wr;
    logic              lat_m2r;
    logic              lat_wm;
    logic [DATA_W-1:0] lat_sd;
    logic [REG_W-1:0]  lat_des;

    // Completion is taken on the edge of the 32nd iteration using the
    // not-yet-registered sum, so the product lands exactly 32 edges after accept.
    assign acc_nxt  = acc + (mplr[0] ? mcand : '0);
    assign mul_done = (cnt >= 6'd31);
    assign product  = (cnt == 6'd32) ? acc : acc_nxt;
    assign ex_ready = (state == IDLE) & ~bus.mem_stall_i;
    assign mul_take = accept & (bus.exe_aluc == OP_MUL);
    assign alu_take = accept & (bus.exe_aluc != OP_MUL);
`else
    assign ex_ready = ~bus.mem_stall_i;
    assign alu_take = accept;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_wr    <= 1'b0;
            r_m2r   <= 1'b0;
            r_wm    <= 1'b0;
            r_res   <= '0;
            r_sd    <= '0;
            r_des   <= '0;
`ifdef EX_MUL_EN
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            lat_wr  <= 1'b0;
            lat_m2r <= 1'b0;
            lat_wm  <= 1'b0;
            lat_sd  <= '0;
            lat_des <= '0;
`endif
        end else if (bus.flush_i) begin
            r_valid <= 1'b0;
`ifdef EX_MUL_EN
            state   <= IDLE;
            cnt     <= '0;
        end else if (state == MUL_BUSY) begin
            // Iterations continue under stall; only the hand-off to MEM waits.
            if (cnt != 6'd32) begin
                acc   <= acc_nxt;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                cnt   <= cnt + 6'd1;
            end
            if (mul_done && !bus.mem_stall_i) begin
                r_valid <= 1'b1;
                r_res   <= product;
                r_wr    <= lat_wr;
                r_m2r   <= lat_m2r;
                r_wm    <= lat_wm;
                r_sd    <= lat_sd;
                r_des   <= lat_des;
                state   <= IDLE;
                cnt     <= '0;
            end
`endif
        end else if (!bus.mem_stall_i) begin
            r_valid <= alu_take;
            if (alu_take) begin
                r_res <= alu_res;
                r_wr  <= wr_eff;
                r_m2r <= bus.exe_mem_to_reg;
                r_wm  <= bus.exe_write_mem;
                r_sd  <= bus.operand_2_i;
                r_des <= bus.des_r_i;
            end
`ifdef EX_MUL_EN
            if (mul_take) begin
                acc     <= '0;
                mcand   <= op_a;
                mplr    <= op_b;
                cnt     <= '0;
                lat_wr  <= wr_eff;
                lat_m2r <= bus.exe_mem_to_reg;
                lat_wm  <= bus.exe_write_mem;
                lat_sd  <= bus.operand_2_i;
                lat_des <= bus.des_r_i;
                state   <= MUL_BUSY;
            end
`endif
        end
    end

    assign bus.ex_ready_o       = ex_ready;
    assign bus.mem_valid_o      = r_valid;
    assign bus.mem_write_reg_o  = r_wr;
    assign bus.mem_mem_to_reg_o = r_m2r;
    assign bus.mem_write_mem_o  = r_wm;
    assign bus.alu_result_o     = r_res;
    assign bus.store_data_o     = r_sd;
    assign bus.mem_des_r_o      = r_des;
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage pipeline: consumes the control bits, operands and destination register held in the ID/EX pipeline register, computes the ALU result, and registers everything the MEM stage needs (EX/MEM boundary). Single-cycle ALU operations flow through at one per cycle. An iterative 32-cycle multiplier is optional; while it runs, the stage stalls ID/EX.

## Interface
- DATA_W, 32, operand and result width
- ALUC_W, 4, ALU opcode width
- REG_W, 5, register-specifier width
- Clock and reset (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid_i  in  1  ID/EX holds a valid instruction
- exe_write_reg, exe_mem_to_reg, exe_write_mem  in  1 each  control bits from ID/EX
- exe_aluc  in  ALUC_W  ALU opcode
- exe_shift  in  1  shift by immediate shamt
- exe_alu_imm  in  1  operand B = immediate
- operand_1_i, operand_2_i, operand_imm_i  in  DATA_W each  source operands, sign/zero-extended immediate
- des_r_i  in  REG_W  destination register
- mem_stall_i  in  1  MEM stage cannot accept this cycle
- flush_i  in  1  synchronous kill of EX contents
- ex_ready_o  out  1  stage accepts an instruction this cycle
- mem_valid_o  out  1  EX/MEM slot valid
- mem_write_reg_o, mem_mem_to_reg_o, mem_write_mem_o  out  1 each  registered control bits
- alu_result_o  out  DATA_W  result / memory address
- store_data_o  out  DATA_W  operand_2 passed for stores
- mem_des_r_o  out  REG_W  registered destination

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LUI (B<<16), 6 SLL, 7 SRL, 8 SRA, 9 SLT (signed, result 0/1), 10 MUL (low DATA_W bits of product), 11–15 reserved (result 0, no trap).
- Operand A = operand_1_i; B = exe_alu_imm ? operand_imm_i : operand_2_i.
- Shifts: value = operand_2_i; amount = exe_shift ? operand_imm_i[10:6] : operand_1_i[4:0].
- ADD/SUB wrap modulo 2^DATA_W; no overflow flag.
- Accept = id_valid_i & ex_ready_o. ex_ready_o = (state==IDLE) & ~mem_stall_i.
- FSM: IDLE; MUL_BUSY (6-bit counter 0..32, radix-2 shift-add on latched A, B).
- IDLE + accept non-MUL: output registers load result, controls, des_r; mem_valid_o=1.
- IDLE + accept MUL: latch operands, counter=0, go MUL_BUSY; mem_valid_o=0 next cycle (bubble).
- IDLE, no accept, ~mem_stall_i: mem_valid_o=0, other outputs hold.
- MUL_BUSY: one iteration per cycle; mem_valid_o=0. At counter==32 and ~mem_stall_i: load product + latched controls, mem_valid_o=1, go IDLE. If mem_stall_i, counter saturates at 32 and waits.
- mem_stall_i high: all output registers hold.
- des_r_i==0 forces mem_write_reg_o=0.
- Priority: rst_n > flush_i > mem_stall_i > accept. flush_i clears mem_valid_o, aborts MUL to IDLE; ex_ready_o unaffected by flush_i that cycle.

## Timing
- Reset: state IDLE, counter 0, all outputs 0, except ex_ready_o = ~mem_stall_i.
- Non-MUL latency: accepted at edge N, visible after edge N.
- MUL latency: accepted at edge N, iterations N+1..N+32, result visible after edge N+32 (later if stalled). ex_ready_o low for 32 cycles.
- ex_ready_o is combinational from state and mem_stall_i; no other comb paths input→output.
- Reset asserted mid-MUL: immediate return to IDLE, partial product discarded.

## Configuration
- EX_MUL_EN defined: MUL runs the 32-cycle iterative multiplier as above.
- EX_MUL_EN undefined: no multiplier or MUL_BUSY state; opcode 10 is treated as reserved (result 0, single cycle); ex_ready_o = ~mem_stall_i always.

## Test plan
- Reset mid-stream, then ADD 7+5 with des_r=3 → after one edge mem_valid_o=1, alu_result_o=12, mem_write_reg_o=1.
- SRA with exe_shift=1, operand_2=0x80000000, shamt 4 → 0xF8000000; SLT -1<1 → 1; des_r=0 → mem_write_reg_o=0.
- Back-to-back ADD, SUB, LUI 0x1234 every cycle → three consecutive valid results, last 0x12340000.
- MUL 0xFFFF×0x10001 (EX_MUL_EN) → ex_ready_o low 32 cycles, then 0xFFFFFFFF; mem_stall_i at completion holds result until released.
- flush_i during MUL_BUSY cycle 10 → mem_valid_o stays 0, ex_ready_o high next cycle, next ADD correct.
- EX_MUL_EN undefined: MUL 3×4 → single cycle, result 0, ex_ready_o never drops.
